// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state type.
// Imported by the master RTL and its bench.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RSP   = 3'd5
    } state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) between a master and a slave.
// Signal names keep the M_ prefix used on the master port.
interface axi4_lite_master_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  M_AWADDR;
    logic                      M_AWVALID;
    logic                      M_AWREADY;
    logic [DATA_WIDTH-1:0]     M_WDATA;
    logic [DATA_WIDTH/8-1:0]   M_WSTRB;
    logic                      M_WVALID;
    logic                      M_WREADY;
    logic [1:0]                M_BRESP;
    logic                      M_BVALID;
    logic                      M_BREADY;
    logic [ADDRESS_WIDTH-1:0]  M_ARADDR;
    logic                      M_ARVALID;
    logic                      M_ARREADY;
    logic [DATA_WIDTH-1:0]     M_RDATA;
    logic [1:0]                M_RRESP;
    logic                      M_RVALID;
    logic                      M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID,
        output M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
        input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
        input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID,
        input  M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
        output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
        output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Every AXI output is a register; nothing flows combinationally from AXI inputs.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    axi4_lite_master_if.master       m
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;
    logic   aw_fin;
    logic   w_fin;

    assign aw_hs  = m.M_AWVALID & m.M_AWREADY;
    assign w_hs   = m.M_WVALID & m.M_WREADY;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            m.M_AWADDR  <= '0;
            m.M_AWVALID <= 1'b0;
            m.M_WDATA   <= '0;
            m.M_WSTRB   <= '0;
            m.M_WVALID  <= 1'b0;
            m.M_BREADY  <= 1'b0;
            m.M_ARADDR  <= '0;
            m.M_ARVALID <= 1'b0;
            m.M_RREADY  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m.M_AWADDR  <= cmd_addr;
                            m.M_AWVALID <= 1'b1;
                            m.M_WDATA   <= cmd_wdata;
                            m.M_WSTRB   <= cmd_wstrb;
                            m.M_WVALID  <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            m.M_ARADDR  <= cmd_addr;
                            m.M_ARVALID <= 1'b1;
                            state       <= RADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    // Address and data channels retire independently.
                    if (aw_hs) begin
                        m.M_AWVALID <= 1'b0;
                        m.M_AWADDR  <= '0;
                    end
                    if (w_hs) begin
                        m.M_WVALID <= 1'b0;
                        m.M_WDATA  <= '0;
                        m.M_WSTRB  <= '0;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        m.M_BREADY <= 1'b1;
                        state      <= WRESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WRESP: begin
                    if (m.M_BVALID) begin
                        m.M_BREADY <= 1'b0;
                        rsp_resp   <= m.M_BRESP;
                        rsp_write  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                RADDR: begin
                    if (m.M_ARREADY) begin
                        m.M_ARVALID <= 1'b0;
                        m.M_ARADDR  <= '0;
                        m.M_RREADY  <= 1'b1;
                        state       <= RDATA;
                    end
                end
                RDATA: begin
                    if (m.M_RVALID) begin
                        m.M_RREADY <= 1'b0;
                        rsp_resp   <= m.M_RRESP;
                        rsp_rdata  <= m.M_RDATA;
                        rsp_write  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a configurable AXI4-Lite
// memory slave model with per-channel ready/valid delays.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        ACLK;
    logic        ARESETN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int errors;
    int checks;

    axi4_lite_master_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m         (bus.master)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Slave model configuration and state
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic        r_ovr;
    logic [31:0] cfg_rdata;
    logic        spur_r;
    logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [31:0] mem [logic [31:0]];
    int          aw_cnt, w_cnt, ar_cnt, rsp_cnt, viol;

    assign bus.M_AWREADY = aw_rdy;
    assign bus.M_WREADY  = w_rdy;
    assign bus.M_BVALID  = b_vld;
    assign bus.M_BRESP   = s_bresp;
    assign bus.M_ARREADY = ar_rdy;
    assign bus.M_RVALID  = r_vld | spur_r;
    assign bus.M_RRESP   = s_rresp;
    assign bus.M_RDATA   = s_rdata;

    logic        awv_p, wv_p, arv_p;
    logic [31:0] awa_p, wd_p, ara_p;
    logic [3:0]  ws_p;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        got_aw, got_w, got_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr, tmp;
    logic [3:0]  s_wstrb;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;

    always @(posedge ACLK) begin
        awv_p = bus.M_AWVALID; awa_p = bus.M_AWADDR;
        wv_p  = bus.M_WVALID;  wd_p  = bus.M_WDATA; ws_p = bus.M_WSTRB;
        arv_p = bus.M_ARVALID; ara_p = bus.M_ARADDR;
        aw_hs = awv_p && aw_rdy;
        w_hs  = wv_p && w_rdy;
        b_hs  = b_vld && bus.M_BREADY;
        ar_hs = arv_p && ar_rdy;
        r_hs  = bus.M_RVALID && bus.M_RREADY;
        if (rsp_valid && rsp_ready) rsp_cnt++;
        #1;
        if (!ARESETN) begin
            aw_rdy = 0; w_rdy = 0; b_vld = 0; ar_rdy = 0; r_vld = 0;
            got_aw = 0; got_w = 0; got_ar = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (aw_hs) begin aw_cnt++; got_aw = 1; s_awaddr = awa_p; end
            if (w_hs) begin w_cnt++; got_w = 1; s_wdata = wd_p; s_wstrb = ws_p; end
            if (ar_hs) begin ar_cnt++; got_ar = 1; s_araddr = ara_p; end
            // valid must hold with stable payload until its handshake
            if (awv_p && !aw_hs && (!bus.M_AWVALID || bus.M_AWADDR !== awa_p)) viol++;
            if (wv_p && !w_hs && (!bus.M_WVALID || bus.M_WDATA !== wd_p || bus.M_WSTRB !== ws_p)) viol++;
            if (arv_p && !ar_hs && (!bus.M_ARVALID || bus.M_ARADDR !== ara_p)) viol++;
            if (!bus.M_AWVALID && bus.M_AWADDR !== 32'h0) viol++;
            if (!bus.M_ARVALID && bus.M_ARADDR !== 32'h0) viol++;
            if (!bus.M_WVALID && (bus.M_WDATA !== 32'h0 || bus.M_WSTRB !== 4'h0)) viol++;
            if (bus.M_AWVALID) begin aw_rdy = (aw_wait >= aw_dly); aw_wait++; end
            else begin aw_rdy = 0; aw_wait = 0; end
            if (bus.M_WVALID) begin w_rdy = (w_wait >= w_dly); w_wait++; end
            else begin w_rdy = 0; w_wait = 0; end
            if (bus.M_ARVALID) begin ar_rdy = (ar_wait >= ar_dly); ar_wait++; end
            else begin ar_rdy = 0; ar_wait = 0; end
            if (b_hs) begin
                b_vld = 0; got_aw = 0; got_w = 0;
            end else if (got_aw && got_w && !b_vld) begin
                if (b_wait >= b_dly) begin
                    tmp = mem.exists(s_awaddr) ? mem[s_awaddr] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) tmp[8*i +: 8] = s_wdata[8*i +: 8];
                    mem[s_awaddr] = tmp;
                    b_vld = 1; s_bresp = cfg_bresp; b_wait = 0;
                end else b_wait++;
            end
            if (r_hs && r_vld) begin
                r_vld = 0; got_ar = 0;
            end else if (got_ar && !r_vld) begin
                if (r_wait >= r_dly) begin
                    s_rdata = r_ovr ? cfg_rdata
                            : (mem.exists(s_araddr) ? mem[s_araddr] : 32'h0);
                    s_rresp = r_ovr ? cfg_rresp : RESP_OKAY;
                    r_vld = 1; r_wait = 0;
                end else r_wait++;
            end
        end
    end

    function automatic logic [141:0] outs();
        return {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                bus.M_AWADDR, bus.M_AWVALID, bus.M_WDATA, bus.M_WSTRB,
                bus.M_WVALID, bus.M_BREADY, bus.M_ARADDR, bus.M_ARVALID,
                bus.M_RREADY};
    endfunction

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic rw,
                          output logic [31:0] rd, output logic [1:0] rr);
        int n;
        rw = 1'bx; rd = 'x; rr = 'x;
        @(negedge ACLK);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 0;
            return;
        end
        @(posedge ACLK); #1 cmd_valid = 0;
        n = 0;
        @(negedge ACLK);
        while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
            return;
        end
        rw = rsp_write; rd = rsp_rdata; rr = rsp_resp;
        rsp_ready = 1;
        @(posedge ACLK); #1 rsp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ACLK);
        checks++;
        if (outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h, required 0", outs());
        end
        ARESETN = 1;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        logic rw; logic [31:0] rd; logic [1:0] rr;
        do_cmd(1, 32'h10, 32'hDEAD_BEEF, 4'hF, rw, rd, rr);
        checks++; if (rr !== 2'b00) begin errors++; $display("FAIL wr_resp: got %b, required 00", rr); end
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL wr_flag: got %b, required 1", rw); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h, required 0", rd); end
        do_cmd(0, 32'h10, 32'h0, 4'h0, rw, rd, rr);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h, required deadbeef", rd); end
        checks++; if (rr !== 2'b00) begin errors++; $display("FAIL rd_resp: got %b, required 00", rr); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL rd_flag: got %b, required 0", rw); end
    endtask

    task automatic test_aw_w_order();
        int awd [3] = '{0, 3, 0};
        int wd  [3] = '{3, 0, 0};
        logic rw; logic [31:0] rd; logic [1:0] rr;
        int a0, w0, r0;
        for (int i = 0; i < 3; i++) begin
            aw_dly = awd[i]; w_dly = wd[i];
            a0 = aw_cnt; w0 = w_cnt; r0 = rsp_cnt;
            do_cmd(1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, rw, rd, rr);
            repeat (3) @(negedge ACLK);
            checks++; if (aw_cnt - a0 != 1) begin errors++; $display("FAIL order%0d_aw_hs: got %0d, required 1", i, aw_cnt - a0); end
            checks++; if (w_cnt - w0 != 1) begin errors++; $display("FAIL order%0d_w_hs: got %0d, required 1", i, w_cnt - w0); end
            checks++; if (rsp_cnt - r0 != 1) begin errors++; $display("FAIL order%0d_rsp: got %0d, required 1", i, rsp_cnt - r0); end
            checks++; if (viol != 0) begin errors++; $display("FAIL order%0d_hold: got %0d violations, required 0", i, viol); end
        end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_error_resp();
        logic rw; logic [31:0] rd; logic [1:0] rr;
        b_dly = 5; cfg_bresp = RESP_SLVERR;
        do_cmd(1, 32'h30, 32'h55, 4'hF, rw, rd, rr);
        checks++; if (rr !== 2'b10) begin errors++; $display("FAIL err_bresp: got %b, required 10", rr); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_wr_rdata: got %h, required 0", rd); end
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL err_wr_flag: got %b, required 1", rw); end
        b_dly = 0; cfg_bresp = RESP_OKAY;
        r_ovr = 1; cfg_rresp = RESP_DECERR; cfg_rdata = 32'h1234_5678;
        do_cmd(0, 32'h30, 32'h0, 4'h0, rw, rd, rr);
        checks++; if (rr !== 2'b11) begin errors++; $display("FAIL err_rresp: got %b, required 11", rr); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL err_rdata: got %h, required 12345678", rd); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL err_rd_flag: got %b, required 0", rw); end
        r_ovr = 0;
    endtask

    task automatic test_rsp_stall();
        int n;
        logic [31:0] held;
        @(negedge ACLK);
        cmd_write = 0; cmd_addr = 32'h10; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
        held = rsp_rdata;
        checks++;
        if (held !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_data: got %h, required deadbeef", held); end
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || cmd_ready !== 1'b0 ||
                (bus.M_AWVALID | bus.M_WVALID | bus.M_ARVALID) !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: rsp_valid=%b rdata=%h cmd_ready=%b axi_valid=%b, required 1/deadbeef/0/0",
                         i, rsp_valid, rsp_rdata, cmd_ready, bus.M_AWVALID | bus.M_WVALID | bus.M_ARVALID);
            end
        end
        rsp_ready = 1;
        @(posedge ACLK); #1 rsp_ready = 0;
        n = 0;
        @(negedge ACLK);
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1 cmd_valid = 0;
        n = 0;
        @(negedge ACLK);
        while (!rsp_valid && n < 100) begin @(negedge ACLK); n++; end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stall_next: rsp_valid=%b rdata=%h, required 1/deadbeef", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1;
        @(posedge ACLK); #1 rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        logic rw; logic [31:0] rd; logic [1:0] rr;
        b_dly = 3;
        mem[32'h4] = 32'hA5A5_0004;
        @(negedge ACLK);
        cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h77; cmd_wstrb = 4'hF; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1 cmd_valid = 0;
        n = 0;
        do begin @(posedge ACLK); #2; n++; end
        while (!(bus.M_BREADY && b_vld) && n < 50);
        checks++;
        if (!(bus.M_BREADY && b_vld)) begin
            errors++;
            $display("FAIL rst_reach_wresp: bready=%b bvalid=%b, required 1/1", bus.M_BREADY, b_vld);
        end
        ARESETN = 0;
        #1;
        checks++;
        if (outs() !== '0) begin errors++; $display("FAIL rst_async_outs: got %h, required 0", outs()); end
        @(negedge ACLK); @(negedge ACLK);
        ARESETN = 1;
        b_dly = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin @(negedge ACLK); seen |= rsp_valid; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: rsp_valid seen=%b, required 0", seen); end
        do_cmd(0, 32'h4, 32'h0, 4'h0, rw, rd, rr);
        checks++; if (rd !== 32'hA5A5_0004) begin errors++; $display("FAIL rst_read_data: got %h, required a5a50004", rd); end
        checks++; if (rr !== 2'b00 || rw !== 1'b0) begin errors++; $display("FAIL rst_read_resp: resp=%b write=%b, required 00/0", rr, rw); end
    endtask

    task automatic test_spurious_rvalid();
        logic bad;
        logic rw; logic [31:0] rd; logic [1:0] rr;
        @(negedge ACLK);
        spur_r = 1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            bad |= rsp_valid | bus.M_RREADY | ~cmd_ready;
        end
        spur_r = 0;
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL spur_rvalid: disturbed=%b, required 0", bad); end
        do_cmd(0, 32'h10, 32'h0, 4'h0, rw, rd, rr);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL spur_after_read: got %h, required deadbeef", rd); end
    endtask

    initial begin
        errors = 0; checks = 0;
        ARESETN = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY; r_ovr = 0; cfg_rdata = 0; spur_r = 0;
        aw_rdy = 0; w_rdy = 0; b_vld = 0; ar_rdy = 0; r_vld = 0;
        s_bresp = 0; s_rresp = 0; s_rdata = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0; viol = 0;
        test_reset();
        test_write_read();
        test_aw_w_order();
        test_error_resp();
        test_rsp_stall();
        test_reset_mid();
        test_spurious_rvalid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Bridges a simple single-outstanding command/response interface onto an AXI4-Lite master port. It sits directly upstream of the team's axi4_lite_slave and drives its AW/W/B/AR/R channels. It lets test logic, CPU-side glue or a register sequencer issue one read or write at a time without handling AXI handshakes.

Parameters:
ADDRESS_WIDTH, 32, width of cmd_addr and M_AWADDR/M_ARADDR
DATA_WIDTH, 32, width of data buses; must be 32 or 64

Ports:
ACLK  input  1  clock
ARESETN  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted this cycle when cmd_valid is also high
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDRESS_WIDTH  byte address
cmd_wdata  input  DATA_WIDTH  write data
cmd_wstrb  input  DATA_WIDTH/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_write  output  1  response belongs to a write
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
rsp_resp  output  2  captured BRESP/RRESP
M_AWADDR  output  ADDRESS_WIDTH  write address
M_AWVALID  output  1  write address valid
M_AWREADY  input  1  write address ready
M_WDATA  output  DATA_WIDTH  write data
M_WSTRB  output  DATA_WIDTH/8  write strobes
M_WVALID  output  1  write data valid
M_WREADY  input  1  write data ready
M_BRESP  input  2  write response
M_BVALID  input  1  write response valid
M_BREADY  output  1  write response ready
M_ARADDR  output  ADDRESS_WIDTH  read address
M_ARVALID  output  1  read address valid
M_ARREADY  input  1  read address ready
M_RDATA  input  DATA_WIDTH  read data
M_RRESP  input  2  read response
M_RVALID  input  1  read data valid
M_RREADY  output  1  read data ready

Behaviour:
- Clocking and reset: single clock ACLK; reset ARESETN is asynchronous, active-low. While reset is asserted, all outputs are 0, state is IDLE, and all capture registers are 0.
- Reset mid-transaction abandons the transaction. No response is produced.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RSP. All AXI valid/ready outputs are registered, or decoded from state plus registered flags. There is no combinational path from AXI inputs to AXI outputs.
- IDLE:
  - cmd_ready = 1 here and only here.
  - On cmd_valid, latch addr, wdata, wstrb and write.
  - Go to WRITE (cmd_write = 1) or RADDR (cmd_write = 0).
- WRITE:
  - M_AWVALID and M_WVALID both rise on the first WRITE cycle.
  - Flags aw_done and w_done are set by their own handshakes. Each valid drops the cycle after its own handshake.
  - AW may complete before W, after W, or in the same cycle.
  - When both are done (including simultaneous completion), clear the flags and go to WRESP.
- WRESP: M_BREADY = 1. On M_BVALID, capture M_BRESP, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- RADDR: M_ARVALID = 1 until M_ARREADY is seen, then go to RDATA.
- RDATA: M_RREADY = 1. On M_RVALID, capture M_RDATA and M_RRESP, set rsp_write = 0, then go to RSP.
- RSP: rsp_valid = 1, held with stable outputs until rsp_ready, then go to IDLE. No new command is accepted while in RSP.
- AXI rules:
  - Once asserted, a valid never deasserts before its handshake.
  - M_*ADDR, M_WDATA and M_WSTRB stay stable from valid until handshake, and read 0 when the corresponding valid is low.
  - M_BVALID or M_RVALID outside WRESP/RDATA is ignored.
- Addresses pass through unmodified; no alignment checks.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are forwarded unchanged; no retry.
- Latency against a zero-wait slave: cmd accepted at cycle 0; AW/W/AR valid at cycle 1; B/R handshake no earlier than cycle 2; rsp_valid one cycle after the B/R handshake.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - resp constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the master state enum (3-bit).
- No sub-module. A single FSM plus capture registers is the natural size.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF / wstrb 0xF into axi4_lite_slave, then read 0x10 -> write rsp_resp 00, rsp_write 1; read rsp_rdata 0xDEAD_BEEF, rsp_resp 00.
- Stub slave asserts AWREADY 3 cycles before WREADY, then WREADY before AWREADY, then both together -> exactly one AW and one W handshake each time; M_AWVALID/M_WVALID held until their own handshake; a single response per command.
- Stub returns BRESP 2'b10 after a 5-cycle BVALID delay and RRESP 2'b11 with RDATA 0x1234_5678 -> rsp_resp 10 and 11 forwarded; rsp_rdata 0x1234_5678 for the read, 0 for the write.
- rsp_ready held low 4 cycles with cmd_valid high -> rsp_valid and data stable, cmd_ready stays 0, no AXI valid asserted until the response is consumed.
- ARESETN pulsed low while in WRESP with BVALID pending -> all outputs 0 immediately (asynchronous), no rsp_valid; after release, a new read of 0x4 completes normally.
- Stub asserts M_RVALID in IDLE -> ignored; rsp_valid stays 0.
